pc_predict: RTL

Parametrised next-PC generator for the fetch stage. It combines a gshare direction predictor, a tagged direct-mapped BTB with per-entry branch type, and a return address stack (RAS) for call/return target prediction. It sits at the front of the pipeline: it is fed resolution info from ID and flush/stall from the pipeline controller, and drives the fetch PC plus prediction metadata to IF.

---
 rtl/pc_predict.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pc_predict.sv
// Next-PC generator for fetch: gshare direction predictor, tagged direct-mapped
// BTB with branch type, and a circular return address stack.
module pc_predict #(
    parameter int          GHR_WIDTH = 10,
    parameter int          BTB_DEPTH = 512,
    parameter int          RAS_DEPTH = 8,
    parameter logic [31:0] INIT_PC   = 32'hbfc00000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_branch_in,
    input  logic                 is_jump_in,
    input  logic                 is_call_in,
    input  logic                 is_return_in,
    input  logic                 is_taken_in,
    input  logic                 is_miss_in,
    input  logic [GHR_WIDTH-1:0] last_pht_index,
    input  logic [31:0]          inst_pc,
    input  logic [31:0]          target_in,
    input  logic                 flush,
    input  logic                 stall,
    input  logic [31:0]          exc_pc,
    output logic                 is_branch_taken,
    output logic [GHR_WIDTH-1:0] pht_index_out,
    output logic [31:0]          pred_target,
    output logic [31:0]          pc_out
);

    localparam int PHT_N = 1 << GHR_WIDTH;
    localparam int BTB_L = $clog2(BTB_DEPTH);
    localparam int TAG_W = 32 - BTB_L - 2;
    localparam int RAS_L = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        BT_COND = 2'b00,
        BT_JUMP = 2'b01,
        BT_CALL = 2'b10,
        BT_RET  = 2'b11
    } btype_e;

    logic [31:0]          pc_out_q, pc_reg_q, pc_reg_d;
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [1:0]           pht_q [PHT_N];
    logic [BTB_DEPTH-1:0] btb_vld_q;
    logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
    logic [31:0]          btb_tgt_q [BTB_DEPTH];
    btype_e               btb_typ_q [BTB_DEPTH];
    logic [31:0]          ras_q [RAS_DEPTH];
    logic [RAS_L-1:0]     sp_q, sp_d;
    logic [RAS_L:0]       cnt_q, cnt_d;

    // ---------------- lookup on pc_out ----------------
    logic [BTB_L-1:0]     rd_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic                 hit;
    btype_e               rd_typ;
    logic [GHR_WIDTH-1:0] pht_idx;
    logic [RAS_L-1:0]     sp_top;
    logic                 ras_nonempty;

    assign rd_idx       = pc_out_q[BTB_L+1:2];
    assign rd_tag       = pc_out_q[31:BTB_L+2];
    assign hit          = btb_vld_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign rd_typ       = btb_typ_q[rd_idx];
    assign pht_idx      = pc_out_q[GHR_WIDTH+1:2] ^ ghr_q;
    assign sp_top       = sp_q - RAS_L'(1);
    assign ras_nonempty = (cnt_q != '0);

    assign is_branch_taken = hit && ((rd_typ != BT_COND) || pht_q[pht_idx][1]);
    assign pred_target     = (rd_typ == BT_RET && ras_nonempty) ? ras_q[sp_top]
                                                                : btb_tgt_q[rd_idx];
    assign pht_index_out   = pht_idx;
    assign pc_out          = pc_out_q;

    // ---------------- next PC ----------------
    always_comb begin
        pc_reg_d = pc_reg_q + 32'd4;
        if (flush)
            pc_reg_d = exc_pc;
        else if (stall)
            pc_reg_d = pc_reg_q;
        else if (is_miss_in)
            pc_reg_d = target_in;
        else if (is_branch_taken)
            pc_reg_d = pred_target;
    end

    // ---------------- RAS control ----------------
    logic commit, ras_push, ras_pop;

    assign commit   = hit && !flush && !stall && !is_miss_in;
    assign ras_push = commit && (rd_typ == BT_CALL);
    assign ras_pop  = commit && (rd_typ == BT_RET) && ras_nonempty;

    // A push onto a full stack overwrites the oldest slot; cnt saturates.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (flush) begin
            sp_d  = '0;
            cnt_d = '0;
        end else if (ras_push) begin
            sp_d = sp_q + RAS_L'(1);
            if (cnt_q != (RAS_L+1)'(RAS_DEPTH))
                cnt_d = cnt_q + (RAS_L+1)'(1);
        end else if (ras_pop) begin
            sp_d  = sp_q - RAS_L'(1);
            cnt_d = cnt_q - (RAS_L+1)'(1);
        end
    end

    // ---------------- resolution-side updates ----------------
    logic [BTB_L-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    btype_e           wr_typ;
    logic [1:0]       pht_old, pht_new;

    assign wr_idx  = inst_pc[BTB_L+1:2];
    assign wr_tag  = inst_pc[31:BTB_L+2];
    assign pht_old = pht_q[last_pht_index];
    assign ghr_d   = is_branch_in ? {ghr_q[GHR_WIDTH-2:0], is_taken_in} : ghr_q;

    always_comb begin
        wr_typ = BT_COND;
        if (is_return_in)
            wr_typ = BT_RET;
        else if (is_call_in)
            wr_typ = BT_CALL;
        else if (is_jump_in)
            wr_typ = BT_JUMP;
    end

    always_comb begin
        pht_new = pht_old;
        if (is_taken_in) begin
            if (pht_old != 2'b11)
                pht_new = pht_old + 2'd1;
        end else if (pht_old != 2'b00) begin
            pht_new = pht_old - 2'd1;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out_q  <= INIT_PC;
            pc_reg_q  <= INIT_PC + 32'd4;
            ghr_q     <= '0;
            sp_q      <= '0;
            cnt_q     <= '0;
            btb_vld_q <= '0;
        end else begin
            pc_out_q <= pc_reg_q;
            pc_reg_q <= pc_reg_d;
            ghr_q    <= ghr_d;
            sp_q     <= sp_d;
            cnt_q    <= cnt_d;
            if (is_branch_in)
                btb_vld_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++)
                pht_q[i] <= 2'b01;
        end else if (is_branch_in) begin
            pht_q[last_pht_index] <= pht_new;
        end
    end

    // Payload arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (rst && is_branch_in) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= target_in;
            btb_typ_q[wr_idx] <= wr_typ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && ras_push)
            ras_q[sp_q] <= pc_out_q + 32'd8;
    end

    logic unused_bits;
    assign unused_bits = ^{inst_pc[1:0], pc_out_q[1:0]};

endmodule
